// File: rtl/shift_pkg.sv
// shift_pkg: shared constants and types for the 16-bit shift execute stage.
//   DATA_W  operand/result width
//   AMT_W   shift-amount width
//   TAG_W   destination register tag width
//   shift_op_e  op encoding (SLL, SRA, ROR, RSV)
//   s1_t / s2_t pipeline register payloads
package shift_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;
  localparam int TAG_W  = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_RSV = 2'b11
  } shift_op_e;

  typedef struct packed {
    shift_op_e         op;
    logic [DATA_W-1:0] src;
    logic [AMT_W-1:0]  amt;
    logic [TAG_W-1:0]  dst;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  dst;
  } s2_t;
endpackage

// File: rtl/shift_exec_stage_shifter.sv
// shifter: combinational logical-left / arithmetic-right shifter.
//   in    operand (treated as signed for the right shift)
//   amt   shift amount 0..15
//   mode  1 = shift left logical, 0 = shift right arithmetic
//   out   shifted value
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [AMT_W-1:0]  amt,
  input  logic              mode,
  output logic [DATA_W-1:0] out
);
  always_comb begin
    if (mode) out = in << amt;
    else      out = DATA_W'($signed(in) >>> amt);
  end
endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage valid/ready execute stage for shift ops.
//   S1 registers op/src/amt/dst; the result is formed combinationally from S1
//   and registered into S2 together with the destination tag.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        issue-side handshake
//   in_op, in_src, in_amt, in_dst   op fields (00 SLL, 01 SRA, 10 ROR, 11 pass)
//   out_valid/out_ready      writeback-side handshake
//   out_result, out_dst      registered result and tag
//   z_flag                   1 when the last retired result was zero
// Build option:
//   SHIFT_ROR_EN  when defined, op 10 rotates right; otherwise op 10 passes src.
module shift_exec_stage
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [TAG_W-1:0]  in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_dst,
  output logic              z_flag
);
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic z_q, z_d;

  logic              s1_adv, accept, retire;
  logic [DATA_W-1:0] shf_out, res;

  // S1 moves forward whenever S2 is empty or draining this cycle, so a full
  // pipeline still streams one op per cycle (in_ready depends on out_ready).
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign retire   = s2_valid_q && out_ready;

  shifter u_shifter (
    .in   (s1_q.src),
    .amt  (s1_q.amt),
    .mode (s1_q.op == OP_SLL),
    .out  (shf_out)
  );

  always_comb begin
    res = s1_q.src;
    case (s1_q.op)
      OP_SLL, OP_SRA: res = shf_out;
`ifdef SHIFT_ROR_EN
      OP_ROR: begin
        logic [2*DATA_W-1:0] dbl;
        dbl = {s1_q.src, s1_q.src} >> s1_q.amt;
        res = dbl[DATA_W-1:0];
      end
`endif
      default: res = s1_q.src;
    endcase
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    z_d        = z_q;

    if (accept) begin
      s1_d       = '{op: shift_op_e'(in_op), src: in_src, amt: in_amt, dst: in_dst};
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // An advancing op overwrites S2 even if S2 is retiring in the same cycle.
    if (s1_adv) begin
      s2_d       = '{result: res, dst: s1_q.dst};
      s2_valid_d = 1'b1;
    end else if (retire) begin
      s2_valid_d = 1'b0;
    end

    if (retire) z_d = (s2_q.result == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '{op: OP_SLL, src: '0, amt: '0, dst: '0};
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_q.result;
  assign out_dst    = s2_q.dst;
  assign z_flag     = z_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: directed + streaming bench with a queue scoreboard.
// The driver pushes expected {result, dst} per issued op; a monitor on the
// falling edge pops and compares on every retire and tracks the zero flag.
module tb_shift_exec_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [15:0] in_src = '0;
  logic [3:0]  in_amt = '0;
  logic [3:0]  in_dst = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        z_flag;

  shift_exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src(in_src), .in_amt(in_amt), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst(out_dst), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] q_res[$];
  logic [3:0]  q_dst[$];
  logic        z_model = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-at-a-time reference so it does not share structure with the RTL.
  function automatic logic [15:0] golden(input logic [1:0] op, input logic [15:0] src,
                                         input logic [3:0] amt);
    logic [15:0] r;
    r = src;
    for (int i = 0; i < int'(amt); i++) begin
      case (op)
        2'b00: r = {r[14:0], 1'b0};
        2'b01: r = {r[15], r[15:1]};
`ifdef SHIFT_ROR_EN
        2'b10: r = {r[0], r[15:1]};
`endif
        default: r = r;
      endcase
    end
    return r;
  endfunction

  // Monitor: scoreboard pop on retire, zero-flag tracking.
  always @(negedge clk) begin
    if (rst) begin
      z_model = 1'b0;
    end else begin
      chk("z_flag", {31'd0, z_flag}, {31'd0, z_model});
      if (out_valid && out_ready) begin
        if (q_res.size() == 0) begin
          chk("unexpected_output", {16'd0, out_result}, 32'hDEAD);
        end else begin
          logic [15:0] er;
          logic [3:0]  ed;
          er = q_res.pop_front();
          ed = q_dst.pop_front();
          chk("out_result", {16'd0, out_result}, {16'd0, er});
          chk("out_dst", {28'd0, out_dst}, {28'd0, ed});
          z_model = (er == 16'h0000);
        end
      end
    end
  end

  // Issue one op; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [1:0] op, input logic [15:0] src, input logic [3:0] amt,
                      input logic [3:0] dst, input logic [15:0] exp);
    logic ok;
    q_res.push_back(exp);
    q_dst.push_back(dst);
    in_valid = 1'b1; in_op = op; in_src = src; in_amt = amt; in_dst = dst;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_out_dst", {28'd0, out_dst}, 32'd0);
    chk("rst_z_flag", {31'd0, z_flag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;

    // SLL latency: accepted at edge N, visible after edge N+1.
    send(2'b00, 16'h0001, 4'd4, 4'd3, 16'h0010);
    @(posedge clk); #1;
    chk("sll_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("sll_latency_result", {16'd0, out_result}, 32'h0010);
    idle(2);

    // SRA boundary cases.
    send(2'b01, 16'h8000, 4'd15, 4'd5, 16'hFFFF);
    send(2'b01, 16'h4000, 4'd15, 4'd6, 16'h0000);
    idle(3);
    chk("z_after_zero", {31'd0, z_flag}, 32'd1);

    // Amount 0 for every op, reserved op, rotate.
    send(2'b00, 16'hA5C3, 4'd0, 4'd1, 16'hA5C3);
    send(2'b01, 16'hA5C3, 4'd0, 4'd2, 16'hA5C3);
    send(2'b10, 16'hA5C3, 4'd0, 4'd3, 16'hA5C3);
    send(2'b11, 16'h1234, 4'd7, 4'd4, 16'h1234);
`ifdef SHIFT_ROR_EN
    send(2'b10, 16'h0001, 4'd1, 4'd7, 16'h8000);
    send(2'b10, 16'h00F1, 4'd4, 4'd8, 16'h100F);
`else
    send(2'b10, 16'h0001, 4'd1, 4'd7, 16'h0001);
    send(2'b10, 16'h00F1, 4'd4, 4'd8, 16'h00F1);
`endif
    send(2'b00, 16'h8001, 4'd15, 4'd9, 16'h8000);
    send(2'b01, 16'h7FFF, 4'd3, 4'd10, 16'h0FFF);
    idle(3);

    // Back-pressure: two accepts fill the pipe, third stalls.
    out_ready = 1'b0;
    send(2'b00, 16'h0003, 4'd2, 4'd11, 16'h000C);
    send(2'b01, 16'hF000, 4'd4, 4'd12, 16'hFF00);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_op = 2'b00; in_src = 16'h0101; in_amt = 4'd1; in_dst = 4'd13;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_result", {16'd0, out_result}, 32'h000C);
      chk("bp_hold_dst", {28'd0, out_dst}, 32'd11);
      chk("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 16'h0101, 4'd1, 4'd13, 16'h0202);
    // Remaining two results retire on consecutive cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
    end
    idle(3);

    // Streaming: one accept per cycle.
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  op;
      logic [15:0] src;
      logic [3:0]  amt;
      op  = 2'($urandom_range(0, 3));
      src = 16'($urandom);
      amt = 4'($urandom_range(0, 15));
      send(op, src, amt, 4'(i), golden(op, src, amt));
    end
    chk("stream_cycles", cyc - t0, 32'd200);
    idle(4);

    // Reset mid-flight: make z=1, fill both stages, then reset.
    send(2'b00, 16'h0100, 4'd8, 4'd1, 16'h0000);
    idle(3);
    chk("z_before_reset", {31'd0, z_flag}, 32'd1);
    out_ready = 1'b0;
    send(2'b00, 16'h0011, 4'd1, 4'd2, 16'h0022);
    send(2'b00, 16'h0033, 4'd1, 4'd3, 16'h0066);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_z_flag", {31'd0, z_flag}, 32'd0);
    q_res.delete();
    q_dst.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(2'b01, 16'hC000, 4'd2, 4'd14, 16'hF000);
    idle(5);

    for (int i = 0; i < 20 && q_res.size() != 0; i++) @(posedge clk);
    chk("drain_empty", q_res.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
